// File: rtl/alu_cmd_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_responder
//  Purpose  : Serves a combinational 4-bit alu over valid/ready channels.
//             A command is latched onto registered alu operands and held
//             there for a fixed settle time. The alu results are then
//             captured and returned over a response channel.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_responder #(
  parameter int W             = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  output logic [3:0]       alu_opcode,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  input  logic [W-1:0]     alu_x,
  input  logic [W-1:0]     alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_x,
  output logic [W-1:0]     rsp_y,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // The settle counter is loaded with SETTLE_CYCLES-1 (legal range 1..15).
  localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [3:0]       r_settle_cnt;
  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic [3:0]       r_alu_opcode;
  logic [W-1:0]     r_alu_a;
  logic [W-1:0]     r_alu_b;
  logic [W-1:0]     r_rsp_x;
  logic [W-1:0]     r_rsp_y;
  logic [CNT_W-1:0] r_op_count;
  logic             w_cmd_accept;
  logic             w_rsp_handshake;
  logic             w_settled;

  // r_cmd_ready is only ever high in IDLE, so it also qualifies the accept.
  assign w_cmd_accept    = cmd_valid & r_cmd_ready;
  assign w_rsp_handshake = r_rsp_valid & rsp_ready;
  assign w_settled       = (r_settle_cnt == 4'd0);

  // Next-state decode for the IDLE -> EXEC -> RESP -> IDLE cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd_accept)    w_next_state = S_EXEC;
      S_EXEC:  if (w_settled)       w_next_state = S_RESP;
      S_RESP:  if (w_rsp_handshake) w_next_state = S_IDLE;
      default:                      w_next_state = S_IDLE;
    endcase
  end

  // State register; ready is registered from the next state so it stays low
  // while reset is held and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cmd_ready <= (w_next_state == S_IDLE);
    end
  end

  // Operand registers change only when a command is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_opcode <= 4'd0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
    end else if (w_cmd_accept) begin
      r_alu_opcode <= cmd_opcode;
      r_alu_a      <= cmd_a;
      r_alu_b      <= cmd_b;
    end
  end

  // Settle counter: loaded on accept, counts down to zero during EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle_cnt <= 4'd0;
    end else if (w_cmd_accept) begin
      r_settle_cnt <= c_SETTLE_LOAD;
    end else if (r_state == S_EXEC && !w_settled) begin
      r_settle_cnt <= r_settle_cnt - 4'd1;
    end
  end

  // Response capture at the end of EXEC; data holds until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_x     <= '0;
      r_rsp_y     <= '0;
    end else if (r_state == S_EXEC && w_settled) begin
      r_rsp_valid <= 1'b1;
      r_rsp_x     <= alu_x;
      r_rsp_y     <= alu_y;
    end else if (w_rsp_handshake) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Completed-operation counter, wrapping modulo 2**CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_rsp_handshake) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign busy       = (r_state != S_IDLE);
  assign alu_opcode = r_alu_opcode;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_x      = r_rsp_x;
  assign rsp_y      = r_rsp_y;
  assign op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_cmd_responder
//  Purpose  : Two responders (settle 1 / 8-bit count, settle 3 / 2-bit count)
//             each driving a behavioural alu, with a scoreboard and monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid  [2];
  logic       cmd_ready  [2];
  logic [3:0] cmd_opcode [2];
  logic [3:0] cmd_a      [2];
  logic [3:0] cmd_b      [2];
  logic [3:0] alu_opcode [2];
  logic [3:0] alu_a      [2];
  logic [3:0] alu_b      [2];
  logic [3:0] alu_x      [2];
  logic [3:0] alu_y      [2];
  logic       rsp_valid  [2];
  logic       rsp_ready  [2];
  logic [3:0] rsp_x      [2];
  logic [3:0] rsp_y      [2];
  logic       busy       [2];
  logic [7:0] opc0;
  logic [1:0] opc1;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Behavioural alu: add (y=carry), multiply (y=upper), xor, shift-left,
  // and an arbitrary mix for the remaining opcodes. Result packed {y,x}.
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    logic [7:0] r;
    logic [3:0] t;
    case (op)
      4'b1010: r = {3'b000, {1'b0, a} + {1'b0, b}};
      4'b1100: r = {4'b0000, a} * {4'b0000, b};
      4'b0101: r = {4'b0000, a ^ b};
      4'b1110: begin t = a << b[1:0]; r = {4'b0000, t}; end
      default: r = {b ^ op, a + op};
    endcase
    return r;
  endfunction

  assign {alu_y[0], alu_x[0]} = alu_f(alu_opcode[0], alu_a[0], alu_b[0]);
  assign {alu_y[1], alu_x[1]} = alu_f(alu_opcode[1], alu_a[1], alu_b[1]);

  alu_cmd_responder #(.W(4), .SETTLE_CYCLES(1), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_opcode(cmd_opcode[0]), .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]),
    .alu_opcode(alu_opcode[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
    .alu_x(alu_x[0]), .alu_y(alu_y[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_x(rsp_x[0]), .rsp_y(rsp_y[0]),
    .busy(busy[0]), .op_count(opc0)
  );

  alu_cmd_responder #(.W(4), .SETTLE_CYCLES(3), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_opcode(cmd_opcode[1]), .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]),
    .alu_opcode(alu_opcode[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
    .alu_x(alu_x[1]), .alu_y(alu_y[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_x(rsp_x[1]), .rsp_y(rsp_y[1]),
    .busy(busy[1]), .op_count(opc1)
  );

  function automatic int get_opc(input int k);
    return (k == 0) ? int'(opc0) : int'(opc1);
  endfunction
  function automatic int settle(input int k);
    return (k == 0) ? 1 : 3;
  endfunction
  function automatic int cnt_mod(input int k);
    return (k == 0) ? 256 : 4;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  // Scoreboard queues of expected {y,x}, one per instance.
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  function automatic int q_size(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  // Reference model of the responder's observable behaviour.
  int         since_rst [2];
  int         lat       [2];
  int         vcnt      [2];
  int         last_vcnt [2];
  int         exp_cnt   [2];
  int         last_acc  [2];
  int         last_hs   [2];
  bit         pend      [2];
  bit         vseen     [2];
  logic [11:0] last_cmd [2];
  logic [7:0]  last_rsp [2];

  task automatic mon(input int k);
    logic [7:0] e;
    int s;
    s = settle(k);
    if (rst) begin
      chk("reset_outputs", k, {9'd0, cmd_ready[k], busy[k], rsp_valid[k], alu_opcode[k],
                               alu_a[k], alu_b[k], rsp_x[k], rsp_y[k]}, 32'd0);
      chk("reset_count", k, get_opc(k), 0);
      if (k == 0) q0.delete(); else q1.delete();
      since_rst[k] = 0; pend[k] = 0; vseen[k] = 0; exp_cnt[k] = 0;
      last_cmd[k] = '0; last_rsp[k] = '0; last_acc[k] = -100; last_hs[k] = -100;
      lat[k] = 0; vcnt[k] = 0; last_vcnt[k] = 0;
      return;
    end
    if (since_rst[k] == 0) chk("ready_low_after_release", k, cmd_ready[k], 0);
    else                   chk("ready_vs_busy", k, cmd_ready[k], !busy[k]);
    chk("busy", k, busy[k], pend[k]);
    chk("alu_operands", k, {alu_opcode[k], alu_a[k], alu_b[k]}, last_cmd[k]);
    chk("op_count", k, get_opc(k), exp_cnt[k]);
    if (pend[k]) lat[k]++;
    if (rsp_valid[k]) begin
      vcnt[k]++;
      chk("rsp_not_early", k, (pend[k] && lat[k] >= s), 1);
      if (!vseen[k]) begin
        chk("latency", k, lat[k], s);
        vseen[k] = 1;
      end
      if (q_size(k) == 0) begin
        chk("rsp_without_cmd", k, 1, 0);
        e = 8'hxx;
      end else begin
        e = (k == 0) ? q0[0] : q1[0];
        chk("rsp_data", k, {rsp_y[k], rsp_x[k]}, e);
      end
      if (rsp_ready[k]) begin
        if (q_size(k) != 0) begin
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        last_rsp[k]  = e;
        pend[k]      = 0;
        vseen[k]     = 0;
        last_vcnt[k] = vcnt[k];
        exp_cnt[k]   = (exp_cnt[k] + 1) % cnt_mod(k);
        last_hs[k]   = cyc;
      end
    end else begin
      chk("rsp_data_held", k, {rsp_y[k], rsp_x[k]}, last_rsp[k]);
      if (pend[k] && lat[k] >= s) chk("rsp_late_or_dropped", k, 0, 1);
    end
    if (cmd_valid[k] && cmd_ready[k]) begin
      if (last_hs[k] == cyc - 1)
        chk("accept_spacing", k, cyc - last_acc[k], s + 1 + last_vcnt[k]);
      last_cmd[k] = {cmd_opcode[k], cmd_a[k], cmd_b[k]};
      pend[k] = 1; lat[k] = -1; vcnt[k] = 0; last_acc[k] = cyc;
    end
    since_rst[k]++;
  endtask

  // Monitor: samples on the falling edge, between active edges.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) mon(k);
  end

  // Mid-cycle asynchronous reset with immediate output checks.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("async_reset_outputs", k, {9'd0, cmd_ready[k], busy[k], rsp_valid[k], alu_opcode[k],
                                     alu_a[k], alu_b[k], rsp_x[k], rsp_y[k]}, 32'd0);
      chk("async_reset_count", k, get_opc(k), 0);
    end
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One command on instance k; hold = response cycles with rsp_ready low
  // (0 means rsp_ready high throughout). Junk commands are driven while busy.
  task automatic run_op(input int k, input logic [3:0] op, input logic [3:0] a,
                        input logic [3:0] b, input int hold, input logic [7:0] exp);
    int n;
    bit seen, done, got;
    @(posedge clk); #1;
    cmd_valid[k] = 1'b1; cmd_opcode[k] = op; cmd_a[k] = a; cmd_b[k] = b;
    got = 0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (cmd_ready[k]) got = 1;
    end
    if (!got) begin
      chk("accept_timeout", k, 0, 1);
      cmd_valid[k] = 1'b0;
      return;
    end
    if (k == 0) q0.push_back(exp); else q1.push_back(exp);
    n = 0; seen = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(posedge clk); #1;
      if (hold == 0 || (seen && n >= hold)) begin
        rsp_ready[k] = 1'b1;
        cmd_valid[k] = 1'b0;
      end else begin
        rsp_ready[k]  = 1'b0;
        cmd_valid[k]  = (n == 2) ? 1'b1 : 1'($urandom);
        cmd_opcode[k] = 4'($urandom);
        cmd_a[k]      = 4'($urandom);
        cmd_b[k]      = 4'($urandom);
      end
      @(negedge clk);
      if (rsp_valid[k]) begin
        if (rsp_ready[k]) done = 1;
        else begin seen = 1; n++; end
      end
    end
    if (!done) chk("response_timeout", k, 0, 1);
  endtask

  // Accept on the 3-cycle instance, then reset in its second EXEC cycle.
  task automatic reset_in_exec();
    bit got;
    @(posedge clk); #1;
    rsp_ready[1] = 1'b0;
    cmd_valid[1] = 1'b1; cmd_opcode[1] = 4'b1010; cmd_a[1] = 4'h7; cmd_b[1] = 4'h9;
    got = 0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (cmd_ready[1]) got = 1;
    end
    if (!got) chk("accept_timeout", 1, 0, 1);
    q1.push_back(8'h10);
    @(posedge clk); #1;
    cmd_valid[1] = 1'b0;
    @(posedge clk); #2;
    apply_reset();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 1'b0; cmd_opcode[k] = 4'd0; cmd_a[k] = 4'd0; cmd_b[k] = 4'd0;
      rsp_ready[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    apply_reset();

    // Add, settle 1: x=1000 y=0000.
    run_op(0, 4'b1010, 4'b0011, 4'b0101, 0, 8'h08);
    // Multiply with 5 cycles of backpressure: x=0110 y=0000.
    run_op(0, 4'b1100, 4'b0011, 4'b0010, 5, 8'h06);
    // Reset while the settle-3 instance is in EXEC.
    reset_in_exec();
    // Five back-to-back shifts on the 2-bit counter: counts 1,2,3,0,1.
    for (int i = 0; i < 5; i++) run_op(1, 4'b1110, 4'b1100, 4'b0001, 0, 8'h08);
    // Xor with settle 3: x=0110.
    run_op(1, 4'b0101, 4'b1100, 4'b1010, 2, 8'h06);

    for (int i = 0; i < 24; i++) begin
      int k;
      logic [3:0] op, a, b;
      k  = int'($urandom_range(0, 1));
      op = 4'($urandom); a = 4'($urandom); b = 4'($urandom);
      run_op(k, op, a, b, int'($urandom_range(0, 3)), alu_f(op, a, b));
    end

    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk("scoreboard_drained", k, q_size(k), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/alu_cmd_responder.md
# alu_cmd_responder

Sequential responder that sits in front of the combinational 4-bit `alu` and serves it to an upstream initiator. It accepts one command (opcode, a, b) at a time over a valid/ready command channel and drives registered operands into the `alu`. After a fixed settle time it captures `x`/`y` and returns them over a valid/ready response channel. It is the synthesizable replacement for directly poking the `alu` from a bench, and it is the endpoint that bus-side masters talk to.

## Interface
Parameters:
- `W`, 4, operand/result width; must match the attached `alu`.
- `SETTLE_CYCLES`, 1, cycles `alu` outputs are allowed to settle before capture; legal range 1..15.
- `CNT_W`, 8, width of the completed-operation counter.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: responder can accept a command.
- `cmd_opcode` input 4: `alu` opcode.
- `cmd_a` input W: operand a.
- `cmd_b` input W: operand b.
- `alu_opcode` output 4: registered opcode to `alu`.
- `alu_a` output W: registered a to `alu`.
- `alu_b` output W: registered b to `alu`.
- `alu_x` input W: `alu` primary result.
- `alu_y` input W: `alu` secondary result (carry / product upper bits).
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: downstream accepts response.
- `rsp_x` output W: captured x.
- `rsp_y` output W: captured y.
- `busy` output 1: high in EXEC or RESP.
- `op_count` output CNT_W: number of completed responses, wraps.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `cmd_ready` = 1.
  - On `cmd_valid & cmd_ready`: latch `cmd_opcode`/`cmd_a`/`cmd_b` into `alu_opcode`/`alu_a`/`alu_b`, load settle counter with `SETTLE_CYCLES-1`, go EXEC.
- EXEC:
  - `cmd_ready` = 0. Operand registers hold.
  - Each cycle, if counter ≠ 0, decrement it.
  - When counter = 0: capture `alu_x`→`rsp_x`, `alu_y`→`rsp_y`, set `rsp_valid`, go RESP.
- RESP:
  - `rsp_valid` = 1. `rsp_x`/`rsp_y` are stable until the handshake.
  - On `rsp_valid & rsp_ready`: clear `rsp_valid`, increment `op_count` (mod 2^CNT_W), go IDLE.
- `alu_*` outputs keep the last command after completion. They change only on a command accept.
- `rsp_x`/`rsp_y` keep the last captured value after the handshake.
- The responder does not interpret opcodes. All 16 are passed through; x/y are whatever `alu` produces.
- `cmd_*` inputs are ignored outside the accept cycle. Command values that change while `cmd_ready` = 0 have no effect.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE; `cmd_ready` = 0 while `rst` is high, 1 from the first cycle after release.
  - `rsp_valid` = 0, `busy` = 0.
  - `alu_opcode`, `alu_a`, `alu_b`, `rsp_x`, `rsp_y`, `op_count`, settle counter all = 0.
- `cmd_ready` and `busy` are decoded from registered state; there is no combinational path from `cmd_valid` or `rsp_ready`.
- Latency: if the command is accepted at edge T, `rsp_valid` rises after edge T+SETTLE_CYCLES.
- Throughput: with `rsp_ready` tied high, one command every SETTLE_CYCLES+2 cycles. There is no overlap between a response and the next accept.
- Response backpressure: `rsp_ready` low holds RESP indefinitely, with `rsp_valid` and data stable.
- `rsp_ready` high while in IDLE or EXEC is ignored.
- Reset mid-operation (EXEC or RESP): the in-flight command is dropped, no response is produced, `op_count` is not incremented, and all outputs take their reset values.
- `op_count` at all-ones followed by a completed handshake wraps to 0.

## Test plan
- **Reset:** assert `rst` asynchronously, mid-cycle.
  - All outputs are at reset values immediately.
  - `cmd_ready` goes to 1 one cycle after release.
- **Add, SETTLE_CYCLES=1:** `cmd_opcode`=1010, a=0011, b=0101, `rsp_ready`=1.
  - `rsp_valid` rises 1 cycle after accept.
  - `rsp_x`=1000, `rsp_y`=0000, `op_count`=1.
- **Multiply with backpressure:** `cmd_opcode`=1100, a=0011, b=0010, `rsp_ready` held 0 for 5 cycles, then 1.
  - `rsp_valid` stays high with `rsp_x`=0110, `rsp_y`=0000 stable throughout.
  - `cmd_ready`=0 throughout; a second `cmd_valid` pulse during this window is ignored.
- **Latency, SETTLE_CYCLES=3:** `cmd_opcode`=0101, a=1100, b=1010.
  - `rsp_valid` rises exactly 3 cycles after accept.
  - `rsp_x`=0110.
  - `alu_a`=1100 is held through EXEC and after completion.
- **Reset in EXEC:** accept a command with SETTLE_CYCLES=3, then assert `rst` in the 2nd EXEC cycle.
  - No `rsp_valid` pulse.
  - `op_count` is unchanged at 0.
  - After release, a new command completes normally.
- **Counter wrap, CNT_W=2:** run 5 back-to-back left-shift commands (`cmd_opcode`=1110, a=1100, b=0001).
  - Each response has `rsp_x`=1000.
  - `op_count` sequence is 1,2,3,0,1.
  - Accepts are spaced SETTLE_CYCLES+2 cycles apart.
